// File: rtl/seq_pkg.sv
// Shared encodings and constants for the multi-cycle RISC-V control sequencer.
package seq_pkg;

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;
  localparam int         TIMEOUT_DEFAULT = 255;
  localparam int         WAIT_W          = 16;

endpackage

// File: rtl/mem_watchdog.sv
// Memory wait counter: counts stalled request cycles and flags the cycle that
// would reach the timeout limit, unless the memory completes in that cycle.
module mem_watchdog
  import seq_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic busy,
  input  logic ready,
  output logic expired
);

  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(TIMEOUT - 1);

  logic [WAIT_W-1:0] wait_cnt;
  logic              stalled;

  assign stalled = busy && !ready;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wait_cnt <= '0;
    end else if (stalled && (wait_cnt != '1)) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  // ready in the final cycle suppresses the timeout
  assign expired = stalled && (wait_cnt == LAST_WAIT);

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM with a shared memory port,
// retired-instruction counter and sticky fault state.
module multicycle_sequencer
  import seq_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_reg_write,
  input  logic             dec_mem_write,
  input  logic [1:0]       dec_result_src,
  input  logic             dec_valid_op,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_we,
  output logic             mdr_we,
  output logic             rf_we,
  output logic             pc_we,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret,
  output logic             fault
);

  state_t state_q;
  state_t state_d;
  logic   is_load;
  logic   wd_clear;
  logic   wd_expired;

  assign is_load = (dec_result_src == RESULT_SRC_LOAD);
  assign state   = state_q;

  // Counter restarts whenever a new memory phase begins.
  assign wd_clear = (state_d != state_q) &&
                    ((state_d == S_FETCH) || (state_d == S_MEM));

  mem_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear),
    .busy    (mem_req),
    .ready   (mem_ready),
    .expired (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET:  state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready)       state_d = S_DECODE;
        else if (wd_expired) state_d = S_FAULT;
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (!dec_valid_op)                 state_d = S_FAULT;
        else if (is_load || dec_mem_write) state_d = S_MEM;
        else                               state_d = S_WB;
      end
      S_MEM: begin
        if (mem_ready)       state_d = is_load ? S_WB : S_FETCH;
        else if (wd_expired) state_d = S_FAULT;
      end
      S_WB:     state_d = S_FETCH;
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_FAULT;
    endcase
  end

  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    mdr_we       = 1'b0;
    rf_we        = 1'b0;
    pc_we        = 1'b0;
    fault        = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        ir_we   = mem_ready;
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = dec_mem_write;
        mdr_we       = mem_ready && is_load;
        pc_we        = mem_ready && !is_load;
      end
      S_WB: begin
        rf_we = dec_reg_write;
        pc_we = 1'b1;
      end
      S_FAULT:  fault = 1'b1;
      default:  ;
    endcase
  end

  // Every pc_we marks a retired instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      instret <= '0;
    end else if (pc_we) begin
      instret <= instret + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: per-cycle output vectors checked
// against hand-derived expectations, with TIMEOUT reduced to 4.
module tb_multicycle_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        dec_reg_write;
  logic        dec_mem_write;
  logic [1:0]  dec_result_src;
  logic        dec_valid_op;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic        mem_addr_sel;
  logic        ir_we;
  logic        mdr_we;
  logic        rf_we;
  logic        pc_we;
  logic [2:0]  state;
  logic [31:0] instret;
  logic        fault;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_sequencer #(
    .TIMEOUT (4),
    .CNT_W   (32)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .dec_reg_write  (dec_reg_write),
    .dec_mem_write  (dec_mem_write),
    .dec_result_src (dec_result_src),
    .dec_valid_op   (dec_valid_op),
    .mem_ready      (mem_ready),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr_sel   (mem_addr_sel),
    .ir_we          (ir_we),
    .mdr_we         (mdr_we),
    .rf_we          (rf_we),
    .pc_we          (pc_we),
    .state          (state),
    .instret        (instret),
    .fault          (fault)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rdy);
    mem_ready = rdy;
    #1;
  endtask

  task automatic set_dec(input logic rw, input logic mw, input logic [1:0] rs, input logic ok);
    dec_reg_write  = rw;
    dec_mem_write  = mw;
    dec_result_src = rs;
    dec_valid_op   = ok;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Vector order: state, mem_req, mem_we, mem_addr_sel, ir_we, mdr_we, rf_we, pc_we, fault
  task automatic outs(input string tag, input logic [2:0] st, input logic req, input logic we,
                      input logic asel, input logic ir, input logic mdr, input logic rf,
                      input logic pc, input logic flt);
    chk(tag, {22'd0, state, mem_req, mem_we, mem_addr_sel, ir_we, mdr_we, rf_we, pc_we, fault},
        {22'd0, st, req, we, asel, ir, mdr, rf, pc, flt});
  endtask

  initial begin
    rst = 1'b1;
    mem_ready = 1'b0;
    set_dec(1'b0, 1'b0, 2'b00, 1'b0);
    tick();
    tick();
    outs("reset_outs", 3'd0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("reset_instret", instret, 32'd0);

    // ADD, single-cycle memory
    rst = 1'b0;
    set_dec(1'b1, 1'b0, 2'b00, 1'b1);
    drive(1'b1);
    outs("add_reset", 3'd0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); outs("add_fetch", 3'd1, 1, 0, 0, 1, 0, 0, 0, 0);
    tick(); outs("add_decode", 3'd2, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); outs("add_exec", 3'd3, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); outs("add_wb", 3'd5, 0, 0, 0, 0, 0, 1, 1, 0);
    tick(); chk("add_instret", instret, 32'd1);

    // LW: 2-cycle fetch, 2-cycle data access -> 7 cycles
    set_dec(1'b1, 1'b0, 2'b01, 1'b1);
    drive(1'b0); outs("lw_fetch_wait", 3'd1, 1, 0, 0, 0, 0, 0, 0, 0);
    tick(); drive(1'b1); outs("lw_fetch_rdy", 3'd1, 1, 0, 0, 1, 0, 0, 0, 0);
    tick(); drive(1'b0); outs("lw_decode", 3'd2, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); outs("lw_exec", 3'd3, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); outs("lw_mem_wait", 3'd4, 1, 0, 1, 0, 0, 0, 0, 0);
    tick(); drive(1'b1); outs("lw_mem_rdy", 3'd4, 1, 0, 1, 0, 1, 0, 0, 0);
    tick(); outs("lw_wb", 3'd5, 0, 0, 0, 0, 0, 1, 1, 0);
    tick(); chk("lw_instret", instret, 32'd2);
    outs("lw_next_fetch", 3'd1, 1, 0, 0, 1, 0, 0, 0, 0);

    // SW retires directly from the memory state
    set_dec(1'b0, 1'b1, 2'b00, 1'b1);
    tick(); outs("sw_decode", 3'd2, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); outs("sw_exec", 3'd3, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); outs("sw_mem", 3'd4, 1, 1, 1, 0, 0, 0, 1, 0);
    tick(); chk("sw_instret", instret, 32'd3);
    outs("sw_next_fetch", 3'd1, 1, 0, 0, 1, 0, 0, 0, 0);

    // BEQ + 3 ADDs from a fresh reset: 16 cycles, 4 retired
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_instret", instret, 32'd0);
    outs("rst2_state", 3'd0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    set_dec(1'b0, 1'b0, 2'b00, 1'b1);
    tick(); tick(); tick();
    outs("beq_wb", 3'd5, 0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    set_dec(1'b1, 1'b0, 2'b00, 1'b1);
    for (int i = 0; i < 12; i++) tick();
    chk("beq_add_instret", instret, 32'd4);
    outs("beq_add_fetch", 3'd1, 1, 0, 0, 1, 0, 0, 0, 0);

    // instret wrap
    force dut.instret = 32'hFFFF_FFFF;
    #1;
    release dut.instret;
    #1;
    chk("wrap_preset", instret, 32'hFFFF_FFFF);
    tick(); tick(); tick();
    outs("wrap_wb", 3'd5, 0, 0, 0, 0, 0, 1, 1, 0);
    tick(); chk("wrap_instret", instret, 32'd0);

    // Illegal opcode
    set_dec(1'b0, 1'b0, 2'b00, 1'b0);
    tick(); tick();
    outs("ill_exec", 3'd3, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); outs("ill_fault", 3'd6, 0, 0, 0, 0, 0, 0, 0, 1);
    tick(); outs("ill_sticky", 3'd6, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("ill_instret", instret, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    outs("ill_reset", 3'd0, 0, 0, 0, 0, 0, 0, 0, 0);

    // mem_ready on the last allowed wait cycle wins over the timeout
    set_dec(1'b1, 1'b0, 2'b00, 1'b1);
    tick();
    drive(1'b0);
    for (int i = 0; i < 3; i++) begin
      outs("edge_wait", 3'd1, 1, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
    drive(1'b1);
    outs("edge_rdy", 3'd1, 1, 0, 0, 1, 0, 0, 0, 0);
    tick(); outs("edge_decode", 3'd2, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick(); tick();

    // Fetch timeout after 4 stalled cycles
    drive(1'b0);
    for (int i = 0; i < 4; i++) begin
      outs("to_wait", 3'd1, 1, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
    outs("to_fault", 3'd6, 0, 0, 0, 0, 0, 0, 0, 1);
    drive(1'b1);
    tick(); tick();
    outs("to_sticky", 3'd6, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("to_instret", instret, 32'd1);

    // Reset during a data-memory wait
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    set_dec(1'b1, 1'b0, 2'b01, 1'b1);
    tick(); tick(); tick();
    drive(1'b0);
    outs("rmem_wait", 3'd4, 1, 0, 1, 0, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    outs("rmem_drop", 3'd0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    tick();
    outs("rmem_refetch", 3'd1, 1, 0, 0, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle control FSM that sequences the RISC-V datapath across FETCH, DECODE, EXEC, MEM and WB.
- Shares one unified instruction/data memory port between instruction fetch and load/store.
- Consumes the combinational decoder's outputs (reg-write, mem-write, result-select, legality) and produces per-cycle enables for IR, MDR, register file and PC.
- Keeps a retired-instruction counter; a memory-timeout watchdog raises a sticky fault.

Parameters:
- TIMEOUT, 255, max cycles mem_req may wait for mem_ready before fault (1..65535).
- CNT_W, 32, width of the instret counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- dec_reg_write  in  1  decoder: instruction writes rd.
- dec_mem_write  in  1  decoder: store instruction.
- dec_result_src  in  2  decoder result select; 2'b01 = load.
- dec_valid_op  in  1  decoder recognised the opcode.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request, held until mem_ready.
- mem_we  out  1  write strobe, valid with mem_req.
- mem_addr_sel  out  1  0 = PC address, 1 = ALU result address.
- ir_we  out  1  latch fetched instruction.
- mdr_we  out  1  latch load data.
- rf_we  out  1  register-file write enable.
- pc_we  out  1  commit next PC; the datapath selects PC+4, branch or jump target.
- state  out  3  current state encoding, for debug.
- instret  out  CNT_W  retired-instruction count.
- fault  out  1  sticky timeout or illegal-opcode flag.

Behaviour:
- State encodings: S_RESET=0, S_FETCH=1, S_DECODE=2, S_EXEC=3, S_MEM=4, S_WB=5, S_FAULT=6. Moore outputs are decoded from the state register, except where an output is qualified by mem_ready as listed below.
- rst high: next state S_RESET; instret=0; fault=0; wait counter=0. In S_RESET all outputs are 0. S_RESET always goes to S_FETCH on the next cycle.
- S_FETCH:
  - mem_req=1, mem_we=0, mem_addr_sel=0.
  - On mem_ready: ir_we=1 (same cycle), go to S_DECODE.
- S_DECODE: one cycle with no enables; the decoder settles on the IR. Go to S_EXEC.
- S_EXEC:
  - dec_valid_op=0 -> S_FAULT.
  - Else load (dec_result_src==01) or dec_mem_write -> S_MEM.
  - Else -> S_WB.
- S_MEM:
  - mem_req=1, mem_addr_sel=1, mem_we=dec_mem_write.
  - On mem_ready with a load: mdr_we=1, go to S_WB.
  - On mem_ready with a store: pc_we=1, instret++, go to S_FETCH.
- S_WB: rf_we=dec_reg_write, pc_we=1, instret++, go to S_FETCH. Branches have dec_reg_write=0 and retire here.
- Timing: with single-cycle memory, R/I/branch/jump instructions take 4 cycles, loads 5, stores 4.
- Wait counter:
  - Cleared on entry to S_FETCH or S_MEM.
  - Increments each cycle mem_req=1 and mem_ready=0.
  - Reaching TIMEOUT -> S_FAULT.
  - mem_ready arriving in the same cycle the counter reaches TIMEOUT counts as success; it wins over the timeout.
- mem_ready is ignored whenever mem_req=0.
- S_FAULT: fault=1 and all other outputs 0. Only rst leaves this state.
- instret wraps modulo 2^CNT_W.
- Reset mid-transaction drops mem_req in the next cycle; the memory must tolerate abandoned requests.
- The IR, MDR and register file are written only when their enables are asserted; at most one memory request is outstanding.

Decomposition:
- Shared package seq_pkg:
  - state encodings.
  - RESULT_SRC_LOAD=2'b01.
  - Default TIMEOUT.
- One natural sub-module, mem_watchdog: wait counter plus timeout compare, with inputs clear, busy and ready and output expired.
- The FSM and instret counter stay in the top level.

Test Plan:
- ADD with mem_ready tied 1, from rst: pc_we pulses in cycle 5 after rst falls (RESET, FETCH, DECODE, EXEC, WB); rf_we=1 in WB; instret=1.
- LW with a 2-cycle fetch wait and a 1-cycle data wait:
  - mem_addr_sel goes 0 then 1.
  - ir_we at cycle 2 of FETCH.
  - mdr_we in S_MEM.
  - rf_we and pc_we in WB.
  - Instruction takes 7 cycles.
- SW with mem_ready=1: mem_we=1 and mem_addr_sel=1 in S_MEM; pc_we in S_MEM; rf_we never asserted; instret increments.
- BEQ followed by 3 ADDs, mem_ready=1:
  - rf_we=0 for the branch.
  - instret=4 after 16 cycles.
  - Preset instret to 0xFFFFFFFF via a force, retire one instruction, check it wraps to 0.
- TIMEOUT=4, mem_ready held 0 in FETCH: fault=1 and state=6 after 4 wait cycles; all enables stay 0; fault stays set until rst.
- dec_valid_op=0 at EXEC -> S_FAULT next cycle. Assert rst during a S_MEM wait: mem_req=0 the next cycle, state=S_RESET, then S_FETCH.
